// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default parameters for the LFSR word controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: controller state enum and the WORD_W / BPC / CNT_W defaults.
package lfsr_ctrl_pkg;

    localparam int WORD_W_DEF = 8;   // assembled word width in bits
    localparam int BPC_DEF    = 1;   // LFSR bits delivered per clock
    localparam int CNT_W_DEF  = 16;  // word-count field width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/lfsr_word_ctrl.sv
// Drives an external LFSR and packs its serial output into WORD_W-bit words.
// Latency: a word is presented the cycle after its last chunk is captured.
// Backpressure: word_ready low holds word_data and stalls the LFSR only when the next chunk would complete a word.
//
// Ports:
//   clk, reset_n               clock and synchronous active-low reset
//   start, word_count, stop    run control (word_count 0 = continuous until stop)
//   lfsr_init, lfsr_enable     control towards the LFSR (init pulse, advance enable)
//   lfsr_out, lfsr_valid       BPC bits from the LFSR, valid in the enable cycle
//   word_data, word_valid,
//   word_ready                 assembled word, ready/valid handshake
//   busy, done                 status: not idle / one-cycle end-of-run pulse
// WORD_W must be an integer multiple of BPC.
module lfsr_word_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BPC    = BPC_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              stop,
    output logic              lfsr_init,
    output logic              lfsr_enable,
    input  logic [BPC-1:0]    lfsr_out,
    input  logic              lfsr_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done
);

    localparam int                FILL_W    = $clog2(WORD_W + 1);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WORD_W - BPC);
    localparam logic [FILL_W-1:0] STEP      = FILL_W'(BPC);

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_nxt;
    logic [FILL_W-1:0] fill_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  word_target_q;

    logic              stall;
    logic              capture;
    logic              word_done;
    logic              last_word;
    logic              abort;

    // Earliest captured bit ends up in the MSB of the finished word.
    always_comb begin
        asm_nxt = (asm_q << BPC) | WORD_W'(lfsr_out);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_init   = 1'b0;
        lfsr_enable = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        capture     = 1'b0;
        word_done   = 1'b0;
        last_word   = 1'b0;
        abort       = 1'b0;
        // Only the chunk that would complete a word needs a free output
        // register; earlier chunks keep flowing during backpressure.
        stall       = word_valid && !word_ready && (fill_q == LAST_FILL);

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // stop is meaningless here, so start alone decides.
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                lfsr_init = 1'b1;
                if (stop) begin
                    abort   = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_enable = !stall;
                capture     = lfsr_enable && lfsr_valid;
                word_done   = capture && (fill_q == LAST_FILL);
                last_word   = word_done && (word_target_q != '0) &&
                              (word_cnt_q == word_target_q - CNT_W'(1));
                if (stop) begin
                    abort   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (last_word) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!word_valid) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            asm_q         <= '0;
            fill_q        <= '0;
            word_cnt_q    <= '0;
            word_target_q <= '0;
            word_data     <= '0;
            word_valid    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                word_target_q <= word_count;
                word_cnt_q    <= '0;
                asm_q         <= '0;
                fill_q        <= '0;
            end

            if (word_done) begin
                asm_q     <= '0;
                fill_q    <= '0;
                word_data <= asm_nxt;
            end else if (capture) begin
                asm_q  <= asm_nxt;
                fill_q <= fill_q + STEP;
            end

            // Saturate rather than wrap in continuous mode.
            if (word_done && (word_cnt_q != '1)) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end

            // A completion may coincide with a transfer-out; loading wins so
            // word_valid stays high without a bubble.
            if (word_done) begin
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end

            // Abort drops only the partial word; a word finished on this
            // same edge has already been loaded above and is still drained.
            if (abort) begin
                asm_q  <= '0;
                fill_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Bench for lfsr_word_ctrl: one BPC=1 and one BPC=2 instance share all run controls.
// Latency: n/a (testbench).
// Backpressure: word_ready is driven by directed phases and by $urandom.
module tb_lfsr_word_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [15:0] word_count;
    logic        word_ready;
    logic        lfsr_valid;

    logic        init_o [2];
    logic        en_o   [2];
    logic [7:0]  wd_o   [2];
    logic        wv_o   [2];
    logic        busy_o [2];
    logic        done_o [2];

    logic [0:0]  lo0;
    logic [1:0]  lo1;
    int unsigned sidx0 = 0;
    int unsigned sidx1 = 0;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural reference, one slot per instance (instance i has BPC = i+1).
    // Phase: 0 idle, 1 init, 2 run, 3 drain.
    int          m_ph   [2] = '{0, 0};
    int          m_part [2] = '{0, 0};   // bits of the current word captured
    int unsigned m_cur  [2] = '{0, 0};   // stream position of the next bit
    int          m_nw   [2] = '{0, 0};
    int          m_tgt  [2] = '{0, 0};
    logic        m_mv   [2] = '{1'b0, 1'b0};
    logic [7:0]  m_md   [2] = '{8'h00, 8'h00};

    // Per-run observations used by the literal checks.
    int          hs_cnt    [2] = '{0, 0};
    int          last_hs   [2] = '{0, 0};
    int          min_gap   [2] = '{0, 0};
    int          max_gap   [2] = '{0, 0};
    int          done_cyc  [2] = '{0, 0};
    logic        done_seen [2] = '{1'b0, 1'b0};
    logic [7:0]  first_wd  [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    lfsr_word_ctrl #(.WORD_W(8), .BPC(1), .CNT_W(16)) u_bpc1 (
        .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .stop(stop), .lfsr_init(init_o[0]), .lfsr_enable(en_o[0]),
        .lfsr_out(lo0), .lfsr_valid(lfsr_valid), .word_data(wd_o[0]),
        .word_valid(wv_o[0]), .word_ready(word_ready), .busy(busy_o[0]),
        .done(done_o[0])
    );

    lfsr_word_ctrl #(.WORD_W(8), .BPC(2), .CNT_W(16)) u_bpc2 (
        .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .stop(stop), .lfsr_init(init_o[1]), .lfsr_enable(en_o[1]),
        .lfsr_out(lo1), .lfsr_valid(lfsr_valid), .word_data(wd_o[1]),
        .word_valid(wv_o[1]), .word_ready(word_ready), .busy(busy_o[1]),
        .done(done_o[1])
    );

    // LFSR stub bit stream: 1,0,1,1,0,0,1,0 then a hashed pseudo-random tail.
    function automatic logic stub_bit(input int unsigned k);
        logic [7:0]  p;
        logic [31:0] h;
        p = 8'hB2;
        h = k * 32'h9E3779B1;
        if (k < 8) return p[3'(7 - k)];
        return h[13] ^ h[22];
    endfunction

    // Word built from 8 consecutive stream bits, earliest bit in the MSB.
    function automatic logic [7:0] word_at(input int unsigned s);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = stub_bit(s + 32'(j));
        return w;
    endfunction

    always_comb begin
        lo0 = stub_bit(sidx0);
        lo1 = {stub_bit(sidx1), stub_bit(sidx1 + 1)};
    end

    always @(posedge clk) begin
        if (!reset_n || init_o[0])        sidx0 <= 0;
        else if (en_o[0] && lfsr_valid)   sidx0 <= sidx0 + 1;
        if (!reset_n || init_o[1])        sidx1 <= 0;
        else if (en_o[1] && lfsr_valid)   sidx1 <= sidx1 + 2;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    // Compare process: checks every cycle at negedge, then advances the model at posedge.
    initial begin : cmp
        int np, npart, nnw, ntgt, bpc, gap;
        int unsigned ncur;
        logic nmv, en, cap, comp;
        logic [7:0] nmd;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bpc = i + 1;
                en  = (m_ph[i] == 2) && !(m_mv[i] && !word_ready && (m_part[i] + bpc == 8));
                chk("lfsr_init",   i, 32'(init_o[i]), 32'(m_ph[i] == 1));
                chk("lfsr_enable", i, 32'(en_o[i]),   32'(en));
                chk("word_valid",  i, 32'(wv_o[i]),   32'(m_mv[i]));
                chk("word_data",   i, 32'(wd_o[i]),   32'(m_md[i]));
                chk("busy",        i, 32'(busy_o[i]), 32'(m_ph[i] != 0));
                chk("done",        i, 32'(done_o[i]), 32'(m_ph[i] == 3 && !m_mv[i]));
                if (reset_n && m_ph[i] == 0 && start) begin
                    hs_cnt[i] = 0; min_gap[i] = 1 << 20; max_gap[i] = 0;
                    done_seen[i] = 1'b0; first_wd[i] = 8'h00;
                end
                if (wv_o[i] && word_ready) begin
                    if (hs_cnt[i] == 0) begin
                        first_wd[i] = wd_o[i];
                    end else begin
                        gap = cyc - last_hs[i];
                        if (gap < min_gap[i]) min_gap[i] = gap;
                        if (gap > max_gap[i]) max_gap[i] = gap;
                    end
                    last_hs[i] = cyc;
                    hs_cnt[i]++;
                end
                if (done_o[i]) begin
                    done_seen[i] = 1'b1;
                    done_cyc[i]  = cyc;
                end
            end

            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                bpc   = i + 1;
                np    = m_ph[i];   npart = m_part[i]; ncur = m_cur[i];
                nnw   = m_nw[i];   ntgt  = m_tgt[i];  nmv  = m_mv[i]; nmd = m_md[i];
                en    = (m_ph[i] == 2) && !(m_mv[i] && !word_ready && (m_part[i] + bpc == 8));
                cap   = en && lfsr_valid;
                comp  = cap && (m_part[i] + bpc == 8);
                if (!reset_n) begin
                    np = 0; npart = 0; ncur = 0; nnw = 0; ntgt = 0; nmv = 1'b0; nmd = 8'h00;
                end else begin
                    if (cap) begin
                        ncur  = m_cur[i] + 32'(bpc);
                        npart = m_part[i] + bpc;
                    end
                    if (comp) begin
                        nmd   = word_at(m_cur[i] - 32'(m_part[i]));
                        nmv   = 1'b1;
                        npart = 0;
                        nnw   = m_nw[i] + 1;
                    end else if (m_mv[i] && word_ready) begin
                        nmv = 1'b0;
                    end
                    case (m_ph[i])
                        0: if (start) begin
                               np = 1; ntgt = int'(word_count); nnw = 0; npart = 0;
                           end
                        1: begin
                               ncur = 0; npart = 0;
                               np = stop ? 3 : 2;
                           end
                        2: begin
                               if (comp && m_tgt[i] != 0 && nnw == m_tgt[i]) np = 3;
                               if (stop) begin np = 3; npart = 0; end
                           end
                        default: if (!m_mv[i]) np = 0;
                    endcase
                end
                m_ph[i] = np; m_part[i] = npart; m_cur[i] = ncur; m_nw[i] = nnw;
                m_tgt[i] = ntgt; m_mv[i] = nmv; m_md[i] = nmd;
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] wc, input logic with_stop);
        word_count = wc;
        start      = 1'b1;
        stop       = with_stop;
        cyc_n(1);
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((busy_o[0] || busy_o[1]) && k < budget) begin
            cyc_n(1);
            k++;
        end
        chk({"idle_", tag}, 0, 32'(busy_o[0] | busy_o[1]), 32'd0);
        cyc_n(2);
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_init"},  i, 32'(init_o[i]), 32'd0);
            chk({tag, "_en"},    i, 32'(en_o[i]),   32'd0);
            chk({tag, "_data"},  i, 32'(wd_o[i]),   32'd0);
            chk({tag, "_valid"}, i, 32'(wv_o[i]),   32'd0);
            chk({tag, "_busy"},  i, 32'(busy_o[i]), 32'd0);
            chk({tag, "_done"},  i, 32'(done_o[i]), 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; word_count = 16'd0;
        word_ready = 1'b1; lfsr_valid = 1'b1;
        cyc_n(3);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        cyc_n(2);

        // Three-word run with the fixed stub prefix.
        pulse_start(16'd3, 1'b0);
        wait_idle("A", 100);
        for (int i = 0; i < 2; i++) begin
            chk("A_first_word",     i, 32'(first_wd[i]), 32'hB2);
            chk("A_word_count",     i, 32'(hs_cnt[i]),   32'd3);
            chk("A_done_after_hs",  i, 32'(done_cyc[i]), 32'(last_hs[i] + 1));
        end

        // Twenty cycles of backpressure mid-run.
        pulse_start(16'd6, 1'b0);
        cyc_n(12);
        word_ready = 1'b0;
        cyc_n(20);
        for (int i = 0; i < 2; i++) begin
            chk("B_stalled_enable", i, 32'(en_o[i]), 32'd0);
            chk("B_stalled_valid",  i, 32'(wv_o[i]), 32'd1);
        end
        word_ready = 1'b1;
        wait_idle("B", 100);
        for (int i = 0; i < 2; i++) chk("B_word_count", i, 32'(hs_cnt[i]), 32'd6);

        // Free-running cadence: 8 cycles per word at BPC=1, 4 at BPC=2.
        pulse_start(16'd5, 1'b0);
        wait_idle("D", 100);
        chk("D_gap_min", 0, 32'(min_gap[0]), 32'd8);
        chk("D_gap_max", 0, 32'(max_gap[0]), 32'd8);
        chk("D_gap_min", 1, 32'(min_gap[1]), 32'd4);
        chk("D_gap_max", 1, 32'(max_gap[1]), 32'd4);

        // Release after a stall: completion and transfer share an edge.
        word_ready = 1'b0;
        pulse_start(16'd4, 1'b0);
        cyc_n(25);
        word_ready = 1'b1;
        wait_idle("D2", 100);
        for (int i = 0; i < 2; i++) begin
            chk("D2_no_bubble",  i, 32'(min_gap[i]), 32'd1);
            chk("D2_word_count", i, 32'(hs_cnt[i]),  32'd4);
        end

        // Continuous mode with random valid/ready, then stop.
        pulse_start(16'd0, 1'b0);
        for (int k = 0; k < 4000 && hs_cnt[0] < 100; k++) begin
            lfsr_valid = ($urandom_range(0, 99) < 85);
            word_ready = ($urandom_range(0, 99) < 75);
            cyc_n(1);
        end
        chk("C_100_words", 0, 32'(hs_cnt[0] >= 100), 32'd1);
        stop = 1'b1;
        cyc_n(1);
        stop = 1'b0; word_ready = 1'b1; lfsr_valid = 1'b1;
        wait_idle("C", 50);
        for (int i = 0; i < 2; i++) chk("C_done_seen", i, 32'(done_seen[i]), 32'd1);

        // Reset while a word is held on the output.
        word_ready = 1'b0;
        pulse_start(16'd0, 1'b0);
        cyc_n(15);
        chk("E_valid_before_reset", 0, 32'(wv_o[0]), 32'd1);
        reset_n = 1'b0;
        cyc_n(1);
        chk_reset_vals("E");
        reset_n = 1'b1; word_ready = 1'b1;
        cyc_n(2);

        // start while busy is ignored; start+stop in idle starts a run.
        pulse_start(16'd4, 1'b0);
        cyc_n(5);
        pulse_start(16'd9, 1'b0);
        wait_idle("F", 100);
        for (int i = 0; i < 2; i++) chk("F_word_count", i, 32'(hs_cnt[i]), 32'd4);
        pulse_start(16'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("F_start_wins_busy", i, 32'(busy_o[i]), 32'd1);
            chk("F_start_wins_init", i, 32'(init_o[i]), 32'd1);
        end
        wait_idle("F2", 100);
        for (int i = 0; i < 2; i++) chk("F2_word_count", i, 32'(hs_cnt[i]), 32'd2);

        // Random control soak.
        for (int k = 0; k < 2000; k++) begin
            start      = ($urandom_range(0, 99) < 5);
            stop       = ($urandom_range(0, 99) < 3);
            word_count = 16'($urandom_range(0, 4));
            word_ready = ($urandom_range(0, 99) < 70);
            lfsr_valid = ($urandom_range(0, 99) < 85);
            cyc_n(1);
        end
        start = 1'b0; stop = 1'b0; word_ready = 1'b1; lfsr_valid = 1'b1;
        cyc_n(1);
        stop = 1'b1;
        cyc_n(1);
        stop = 1'b0;
        wait_idle("G", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_word_ctrl.md
LFSR_WORD_CTRL -- requirements
Module: lfsr_word_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning output word width in bits.
REQ-002 SHALL have parameter BPC, default 1, meaning LFSR output bits per clock; WORD_W SHALL be an integer multiple of BPC.
REQ-003 SHALL have parameter CNT_W, default 16, meaning word-count field width.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 word_count  input  CNT_W  words to produce, sampled with start; 0 means continuous until stop.
REQ-008 stop  input  1  abort request; honoured in INIT and RUN.
REQ-009 lfsr_init  output  1  one-cycle init pulse to the LFSR.
REQ-010 lfsr_enable  output  1  LFSR advance enable.
REQ-011 lfsr_out  input  BPC  LFSR output bits, valid in the same cycle as enable.
REQ-012 lfsr_valid  input  1  lfsr_out qualifier.
REQ-013 word_data  output  WORD_W  assembled word.
REQ-014 word_valid / word_ready  output / input  1 each  ready/valid output handshake.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at end of run.

Function
REQ-017 FSM states: IDLE, INIT, RUN, DRAIN.
REQ-018 IDLE->INIT on start; lfsr_init SHALL be high exactly during the single INIT cycle; INIT->RUN next cycle.
REQ-019 lfsr_enable SHALL be high only in RUN and SHALL be low when word_valid && !word_ready and the next chunk would complete a word (stall).
REQ-020 Bits SHALL be captured only when lfsr_enable && lfsr_valid: assembly <= (assembly << BPC) | lfsr_out, so the earliest bit ends up in the MSB.
REQ-021 A fill counter SHALL count captured bits; when it reaches WORD_W, the completed word SHALL move to the output register on the same edge, the counter SHALL clear, and word_valid SHALL rise next cycle.
REQ-022 The output register SHALL hold word_data stable while word_valid && !word_ready; a transfer SHALL occur on word_valid && word_ready.
REQ-023 Simultaneous transfer-out and word completion in one cycle SHALL load the new word with word_valid staying high, with no bubble.
REQ-024 Words produced SHALL be counted; with word_count != 0, RUN->DRAIN on the edge the word_count-th word is loaded.
REQ-025 stop in INIT or RUN SHALL discard the partial assembly and go to DRAIN; a stop in INIT SHALL still allow the already-issued init pulse.
REQ-026 DRAIN->IDLE once the output register is empty; done SHALL pulse in that transition cycle.
REQ-027 start while busy SHALL be ignored; stop in IDLE or DRAIN SHALL be ignored; if start and stop coincide in IDLE, start wins and stop is ignored.
REQ-028 The word counter SHALL be CNT_W bits and SHALL not wrap in continuous mode; its saturation SHALL have no effect.

Reset
REQ-029 reset_n low at a clock edge SHALL force IDLE and clear assembly, counters and the output register, including mid-run.
REQ-030 Reset values: lfsr_init=0, lfsr_enable=0, word_data=0, word_valid=0, busy=0, done=0.

Structure
REQ-031 The state enum and the WORD_W/BPC/CNT_W defaults SHALL live in package lfsr_ctrl_pkg.
REQ-032 No sub-module; galois_lfsr SHALL be instantiated beside this block at the next level up, with port-to-port connection.

Verification
REQ-033 Run: WORD_W=8, BPC=1, word_count=3, word_ready=1, LFSR stub emitting 1,0,1,1,0,0,1,0,... -> first word 8'hB2, exactly 3 words, done one cycle after the last handshake.
REQ-034 Backpressure: word_ready=0 for 20 cycles mid-run -> lfsr_enable drops, word_data stable, no bit lost, sequence continues from the stall point once ready=1.
REQ-035 Continuous: word_count=0 for 100 words, then stop mid-word -> partial bits discarded, pending word delivered, done pulses, busy=0.
REQ-036 BPC=2, WORD_W=8 -> word every 4 enabled cycles, and back-to-back words with ready=1 have no bubble.
REQ-037 reset_n low during RUN with word_valid=1 -> next cycle all outputs at reset values, state IDLE.
REQ-038 start pulsed during RUN, and start with stop in IDLE -> first ignored; second starts the run.
